// File: rtl/alu_defs_pkg.sv
// rtl/alu_defs_pkg.sv - shared ALU divider constants, state encoding and the invert-plus-one helper
package alu_defs_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIXUP  = 2'd2,
    DONE   = 2'd3
  } div_state_e;

  function automatic logic [DIV_WIDTH-1:0] twos_neg(input logic neg, input logic [DIV_WIDTH-1:0] x);
    return neg ? (~x + DIV_WIDTH'(1)) : x;
  endfunction

endpackage

// File: rtl/div32_seq_if.sv
// rtl/div32_seq_if.sv - start/done request and result bundle between the control unit and the divider
interface div32_seq_if;
  import alu_defs_pkg::*;

  logic                 start;
  logic [DIV_WIDTH-1:0] dividend;
  logic [DIV_WIDTH-1:0] divisor;
  logic                 busy;
  logic                 done;
  logic [DIV_WIDTH-1:0] quotient;
  logic [DIV_WIDTH-1:0] remainder;
  logic                 div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/twos_mag32.sv
// rtl/twos_mag32.sv - splits a two's-complement word into sign and unsigned magnitude
module twos_mag32
  import alu_defs_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] x,
  output logic                 sign,
  output logic [DIV_WIDTH-1:0] mag
);

  assign sign = x[DIV_WIDTH-1];
  assign mag  = twos_neg(sign, x);

endmodule

// File: rtl/div32_seq.sv
// rtl/div32_seq.sv - sequential signed restoring divider, one quotient bit per cycle
// Optional DIV32_ZERO_TRAP_EN: divisor==0 short-circuits to DONE with div_by_zero=1.
module div32_seq
  import alu_defs_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
)
(
  input  logic        clock,
  input  logic        clear,
  div32_seq_if.slave  bus
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dmag_q, dmag_d;
  logic [WIDTH-1:0] qmag_q, qmag_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic             sign_quo_q, sign_quo_d;
  logic             sign_rem_q, sign_rem_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic             dvd_sign, dvs_sign;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   shifted, trial;
  logic             qbit;

  twos_mag32 u_dvd_mag (.x(bus.dividend), .sign(dvd_sign), .mag(dvd_mag));
  twos_mag32 u_dvs_mag (.x(bus.divisor),  .sign(dvs_sign), .mag(dvs_mag));

  // Partial remainder stays below |divisor| <= 2^(WIDTH-1), so WIDTH+1 bits never overflow.
  assign shifted = {prem_q, qmag_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dmag_q};
  assign qbit    = ~trial[WIDTH];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dmag_d      = dmag_q;
    qmag_d      = qmag_q;
    prem_d      = prem_q;
    sign_quo_d  = sign_quo_q;
    sign_rem_d  = sign_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          dmag_d     = dvs_mag;
          qmag_d     = dvd_mag;
          prem_d     = '0;
          sign_quo_d = dvd_sign ^ dvs_sign;
          sign_rem_d = dvd_sign;
          cnt_d      = '0;
          state_d    = DIVIDE;
        end
      end
      DIVIDE: begin
`ifdef DIV32_ZERO_TRAP_EN
        if (cnt_q == '0 && dmag_q == '0) begin
          quotient_d  = '0;
          remainder_d = twos_neg(sign_rem_q, qmag_q);
          dbz_d       = 1'b1;
          state_d     = DONE;
        end else begin
`else
        begin
`endif
          prem_d = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
          qmag_d = {qmag_q[WIDTH-2:0], qbit};
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = FIXUP;
          end
        end
      end
      FIXUP: begin
        quotient_d  = twos_neg(sign_quo_q, qmag_q);
        remainder_d = twos_neg(sign_rem_q, prem_q);
        dbz_d       = 1'b0;
        state_d     = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dmag_q      <= '0;
      qmag_q      <= '0;
      prem_q      <= '0;
      sign_quo_q  <= 1'b0;
      sign_rem_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dmag_q      <= dmag_d;
      qmag_q      <= qmag_d;
      prem_q      <= prem_d;
      sign_quo_q  <= sign_quo_d;
      sign_rem_q  <= sign_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule
